// File: rtl/pkg_opengpu.sv
// Shared OpenGPU core constants and types: register file geometry and issue-controller state.
// Pure definitions; no timing or flow control.
package pkg_opengpu;

  localparam int REG_ADDR_WIDTH   = 5;
  localparam int ISSUE_PERF_WIDTH = 32;

  typedef enum logic [1:0] {
    ISSUE_RUN     = 2'b00,
    ISSUE_BR_WAIT = 2'b01,
    ISSUE_FLUSH   = 2'b10
  } issue_state_t;

endpackage

// File: rtl/issue_scoreboard_ctrl_reg_scoreboard.sv
// Per-register write-pending scoreboard with writeback-bypassed lookups; x0 never pending.
// Lookups are zero-cycle; set/clear land at the next edge. There is no backpressure: set wins over clear.
module reg_scoreboard
  import pkg_opengpu::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_vld,
  input  logic [REG_ADDR_WIDTH-1:0] set_idx,
  input  logic                      clr_vld,
  input  logic [REG_ADDR_WIDTH-1:0] clr_idx,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_idx,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_idx,
  input  logic [REG_ADDR_WIDTH-1:0] rd_idx,
  output logic                      rs1_pend,
  output logic                      rs2_pend,
  output logic                      rd_pend,
  output logic [NUM_REGS-1:0]       pending
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] pend_eff;

  // The register file is write-through, so a same-cycle writeback already satisfies readers.
  always_comb begin
    pend_eff = pending_q;
    if (clr_vld) begin
      pend_eff[clr_idx] = 1'b0;
    end
    rs1_pend = pend_eff[rs1_idx];
    rs2_pend = pend_eff[rs2_idx];
    rd_pend  = pend_eff[rd_idx];
  end

  always_comb begin
    pending_d = pending_q;
    if (clr_vld) begin
      pending_d[clr_idx] = 1'b0;
    end
    if (set_vld) begin
      pending_d[set_idx] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/issue_scoreboard_ctrl.sv
// In-order issue control: RAW/WAW hazard checks, control-flow serialisation, fetch/decode flush.
// Issue is combinational (zero-cycle); stalls decode while ex_ready is low, a hazard is open, or a branch is unresolved.
module issue_scoreboard_ctrl
  import pkg_opengpu::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int PERF_WIDTH = ISSUE_PERF_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic                      id_reg_write,
  input  logic                      id_ctrl_flow,
  input  logic                      ex_ready,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      br_valid,
  input  logic                      br_taken,
  output logic                      issue,
  output logic                      stall_decode,
  output logic                      flush_decode,
  output logic                      flush_fetch,
  output logic [NUM_REGS-1:0]       pending,
  output logic [1:0]                state_out,
  output logic                      proto_err,
  output logic [PERF_WIDTH-1:0]     stall_cycles
);

  issue_state_t          state_q, state_d;
  logic                  proto_err_q, proto_err_d;
  logic [PERF_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic                  rs1_pend, rs2_pend, rd_pend;
  logic                  raw_hz, waw_hz;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_vld  (issue && id_reg_write),
    .set_idx  (id_rd),
    .clr_vld  (wb_valid),
    .clr_idx  (wb_rd),
    .rs1_idx  (id_rs1),
    .rs2_idx  (id_rs2),
    .rd_idx   (id_rd),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .rd_pend  (rd_pend),
    .pending  (pending)
  );

  always_comb begin
    state_d        = state_q;
    proto_err_d    = proto_err_q;
    stall_cycles_d = stall_cycles_q;

    raw_hz       = (id_uses_rs1 && rs1_pend) || (id_uses_rs2 && rs2_pend);
    waw_hz       = id_reg_write && rd_pend;
    flush_decode = (state_q == ISSUE_FLUSH);
    flush_fetch  = flush_decode;
    issue        = id_valid && ex_ready && !raw_hz && !waw_hz &&
                   (state_q == ISSUE_RUN) && !flush_decode;
    stall_decode = id_valid && !issue && !flush_decode;

    case (state_q)
      ISSUE_RUN: begin
        if (issue && id_ctrl_flow) begin
          state_d = ISSUE_BR_WAIT;
        end
      end
      ISSUE_BR_WAIT: begin
        if (br_valid) begin
          state_d = br_taken ? ISSUE_FLUSH : ISSUE_RUN;
        end
      end
      ISSUE_FLUSH: state_d = ISSUE_RUN;
      default:     state_d = ISSUE_RUN;
    endcase

    // A resolution is only legal while a control-flow op is outstanding.
    if (br_valid && (state_q != ISSUE_BR_WAIT)) begin
      proto_err_d = 1'b1;
    end

    if (id_valid && !issue && (state_q != ISSUE_FLUSH) && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ISSUE_RUN;
      proto_err_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      proto_err_q    <= proto_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign state_out    = state_q;
  assign proto_err    = proto_err_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/issue_scoreboard_ctrl.md
Name: issue_scoreboard_ctrl

Overview:
- Issue controller for the in-order core pipeline. It sits between the decode stage and execute.
- Tracks registers with writes in flight using a per-register pending scoreboard.
- Decides each cycle whether the instruction held in decode may issue, and drives the decode/fetch stall and flush controls.
- Serialises control flow: after a branch or jump issues, no further issue until execute resolves it; a taken resolution flushes fetch and decode.

Parameters:
- NUM_REGS, 32, architectural register count (must equal 2**REG_ADDR_WIDTH from pkg_opengpu).
- PERF_WIDTH, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode output register holds a valid instruction
- id_rs1  in  REG_ADDR_WIDTH  source 1 address
- id_rs2  in  REG_ADDR_WIDTH  source 2 address
- id_rd  in  REG_ADDR_WIDTH  destination address
- id_uses_rs1  in  1  instruction reads rs1
- id_uses_rs2  in  1  instruction reads rs2 (R-type, store, branch)
- id_reg_write  in  1  instruction writes rd
- id_ctrl_flow  in  1  branch, jump or ret
- ex_ready  in  1  execute can accept (0 while a multi-cycle DIV/REM is busy)
- wb_valid  in  1  writeback this cycle
- wb_rd  in  REG_ADDR_WIDTH  writeback destination
- br_valid  in  1  execute resolves the outstanding control-flow op
- br_taken  in  1  resolution redirects PC
- issue  out  1  instruction in decode advances to execute this cycle
- stall_decode  out  1  hold decode output register
- flush_decode  out  1  invalidate decode output register
- flush_fetch  out  1  invalidate fetch output
- pending  out  NUM_REGS  scoreboard contents (bit r = write to r in flight)
- state_out  out  2  current FSM state encoding
- proto_err  out  1  sticky: br_valid seen outside BR_WAIT
- stall_cycles  out  PERF_WIDTH  saturating count of cycles with id_valid && !issue

Behaviour:
- Reset (rst high at a posedge): pending=0, FSM=RUN, proto_err=0, stall_cycles=0. All combinational outputs follow from these registers: issue=0, stall_decode=0, flush_*=0 unless inputs demand otherwise. Reset mid-operation discards all in-flight state; no partial clearing.
- Hazard, combinational:
  - raw_hz = (id_uses_rs1 && pend_eff[id_rs1]) || (id_uses_rs2 && pend_eff[id_rs2]).
  - waw_hz = id_reg_write && pend_eff[id_rd].
  - pend_eff = pending with bit wb_rd cleared when wb_valid. The regfile is write-through, so same-cycle writeback releases the hazard.
- Register 0 is never pending: set and clear of bit 0 are suppressed, and pending[0] reads 0.
- issue = id_valid && ex_ready && !raw_hz && !waw_hz && state==RUN && !flush_decode.
- stall_decode = id_valid && !issue && !flush_decode.
- Scoreboard update at each posedge:
  - Clear bit wb_rd if wb_valid.
  - Set bit id_rd if issue && id_reg_write.
  - Set wins when both hit the same register in one cycle.
- FSM (2'b00 RUN, 2'b01 BR_WAIT, 2'b10 FLUSH):
  - RUN -> BR_WAIT when issue && id_ctrl_flow.
  - BR_WAIT: issue=0. On br_valid && br_taken -> FLUSH. On br_valid && !br_taken -> RUN; issue is permitted again the following cycle.
  - FLUSH: flush_decode=1, flush_fetch=1 for exactly one cycle, issue=0, then -> RUN.
  - br_valid and issue of a new control-flow op cannot coincide, because BR_WAIT blocks issue.
- br_valid in RUN or FLUSH: ignored for state, proto_err set (sticky until rst).
- Writebacks continue to clear pending bits in every state.
- stall_cycles: increments when id_valid && !issue && state!=FLUSH; saturates at all-ones.
- Latency: issue decision is zero-cycle combinational from decode outputs. Scoreboard state is visible the next cycle.

Decomposition:
- pkg_opengpu gains:
  - an issue_state_t enum (RUN/BR_WAIT/FLUSH, 2 bits);
  - the ISSUE_PERF_WIDTH default constant.
- REG_ADDR_WIDTH comes from the package as already defined.
- One sub-module, reg_scoreboard: owns the pending vector, set/clear/zero-register rules, and the pend_eff lookup ports. The FSM and counter stay in the top.

Test Plan:
- Issue ADD x3 (rd=3); next cycle ADD x4,x3,x1 with no writeback -> issue=0, stall_decode=1, pending[3]=1; assert wb_valid, wb_rd=3 -> issue=1 the same cycle.
- Issue writes to x0 repeatedly -> pending stays 32'h0, dependent readers of x0 issue with no stall.
- Same-cycle wb_rd=5 and issue with id_rd=5 -> pending[5]=1 afterwards.
- Issue BEQ; hold id_valid with an independent ADD -> state_out=01, issue=0 for 3 cycles; br_valid=1, br_taken=1 -> next cycle flush_decode=flush_fetch=1, state_out=10; then RUN.
- BEQ not taken -> BR_WAIT to RUN with no flush; the following ADD issues 1 cycle after br_valid.
- Hold ex_ready=0 for 10 cycles with id_valid=1 -> stall_cycles=10. br_valid pulsed in RUN -> proto_err=1. Then rst for one cycle -> pending=0, state_out=00, proto_err=0, stall_cycles=0.
